// File: rtl/uart_rx_deframer.sv
// -----------------------------------------------------------------------------
// uart_rx_deframer
//
// Oversampled UART receiver. It finds a start bit on an idle-high line,
// majority-votes three mid-bit samples per bit, shifts DATA_WIDTH data bits in
// LSB first, optionally checks a parity bit, checks the stop bit and reports
// the frame one cycle after the stop bit has been sampled.
//
// Ports
//   CLK        : clock, all state changes on the rising edge
//   RST        : asynchronous active-high reset
//   RX_IN      : serial line, idle high, already synchronised to CLK
//   PRESCALE   : CLK cycles per bit (8, 16 or 32), latched at start detect
//   PAR_EN     : 1 = a parity bit follows the data, latched at start detect
//   PAR_TYP    : 0 = even parity, 1 = odd parity, latched at start detect
//   P_DATA     : last correctly received data word
//   DATA_VALID : one-cycle pulse when a frame is accepted
//   PAR_ERR    : parity mismatch in the last frame
//   STP_ERR    : stop bit sampled low in the last frame
//   BUSY       : high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module uart_rx_deframer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [5:0]            PRESCALE,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR,
  output logic                  BUSY
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                state;
  state_t                next_state;

  logic [5:0]            edge_cnt;
  logic [5:0]            prescale_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic [BW-1:0]         bit_cnt;
  logic [2:0]            samples;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  par_bad;
  logic                  stop_ok;
  logic                  result_pending;

  logic [5:0]            half;
  logic                  last_edge;
  logic                  sample_en;
  logic                  bit_value;
  logic                  data_done;

  // Bit timing, all relative to the configuration latched for this frame.
  assign half      = prescale_q >> 1;
  assign last_edge = (edge_cnt == prescale_q - 6'd1);
  assign sample_en = (state != IDLE) &&
                     ((edge_cnt == half - 6'd1) ||
                      (edge_cnt == half) ||
                      (edge_cnt == half + 6'd1));
  // 2-of-3 vote over the three mid-bit samples; read only at the last edge,
  // by which time all three have been captured.
  assign bit_value = (samples[0] & samples[1]) |
                     (samples[0] & samples[2]) |
                     (samples[1] & samples[2]);
  assign data_done = (bit_cnt == LAST_BIT);

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      // NOTE: registered state uses non-blocking assignments so every flop
      // updates from values sampled before the edge, independent of order.
      state <= next_state;
    end
  end

  // Next-state and FSM outputs.
  always_comb begin
    // NOTE: every variable gets a default first so no path through the case
    // leaves it unassigned, which would otherwise infer a latch.
    next_state = state;
    BUSY       = (state != IDLE);
    unique case (state)
      IDLE:   if (!RX_IN) next_state = START;
      START:  if (last_edge) next_state = bit_value ? IDLE : DATA;
      DATA:   if (last_edge && data_done) next_state = par_en_q ? PARITY : STOP;
      PARITY: if (last_edge) next_state = STOP;
      STOP:   if (last_edge) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath: counters, sampling, shift register and frame result.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      edge_cnt       <= '0;
      prescale_q     <= '0;
      par_en_q       <= 1'b0;
      par_typ_q      <= 1'b0;
      bit_cnt        <= '0;
      samples        <= '0;
      // NOTE: the shift register is reset like every other flop because it
      // is only a word wide and keeps reset behaviour fully deterministic.
      shift_q        <= '0;
      par_bad        <= 1'b0;
      stop_ok        <= 1'b0;
      result_pending <= 1'b0;
      P_DATA         <= '0;
      DATA_VALID     <= 1'b0;
      PAR_ERR        <= 1'b0;
      STP_ERR        <= 1'b0;
    end else begin
      DATA_VALID <= 1'b0;

      // Frame result, registered the cycle after the stop bit's last edge.
      if (result_pending) begin
        result_pending <= 1'b0;
        if (!par_bad && stop_ok) begin
          DATA_VALID <= 1'b1;
          P_DATA     <= shift_q;
        end else begin
          PAR_ERR <= par_bad;
          STP_ERR <= !stop_ok;
        end
      end

      if (state == IDLE) begin
        if (!RX_IN) begin
          // The detecting cycle is edge 0 of the start bit.
          edge_cnt   <= 6'd1;
          prescale_q <= PRESCALE;
          par_en_q   <= PAR_EN;
          par_typ_q  <= PAR_TYP;
        end else begin
          edge_cnt <= '0;
        end
      end else begin
        edge_cnt <= last_edge ? 6'd0 : edge_cnt + 6'd1;
        if (sample_en) samples <= {samples[1:0], RX_IN};

        if (last_edge) begin
          unique case (state)
            START: begin
              // A confirmed start bit is the point where the previous frame's
              // error flags are released; a rejected glitch leaves them alone.
              if (!bit_value) begin
                bit_cnt <= '0;
                par_bad <= 1'b0;
                PAR_ERR <= 1'b0;
                STP_ERR <= 1'b0;
              end
            end
            DATA: begin
              shift_q <= {bit_value, shift_q[DATA_WIDTH-1:1]};
              bit_cnt <= data_done ? '0 : bit_cnt + 1'b1;
            end
            PARITY: begin
              par_bad <= (bit_value != ((^shift_q) ^ par_typ_q));
            end
            STOP: begin
              stop_ok        <= bit_value;
              result_pending <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule
